// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle add/sub that processes CHUNK bits per clock.
// Optional signed saturation on overflow: define CHUNKED_ADDER_SAT_EN.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] opa, opb;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic             accept, last;
    logic [CHUNK-1:0] sa, sb;
    logic [CHUNK:0]   ssum;
    logic             ovf_det;
    int               base;

    always_comb begin
        base    = int'(idx) * CHUNK;
        sa      = opa[base +: CHUNK];
        sb      = opb[base +: CHUNK];
        ssum    = {1'b0, sa} + {1'b0, sb} + {{CHUNK{1'b0}}, carry};
        // Result MSB comes from the top bit of the final slice.
        ovf_det = (opa[WIDTH-1] == opb[WIDTH-1]) &&
                  (ssum[CHUNK-1] != opa[WIDTH-1]);
        accept  = start && (state != RUN);
        last    = (idx == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            opa   <= acc ? sum : a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == RUN) begin
            sum[base +: CHUNK] <= ssum[CHUNK-1:0];
            carry <= ssum[CHUNK];
            idx   <= idx + 1'b1;
            if (last) begin
                cout <= ssum[CHUNK];
                ovf  <= ovf_det;
`ifdef CHUNKED_ADDER_SAT_EN
                if (ovf_det)
                    sum <= opa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
`else
`endif
            end
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Testbench for chunked_adder: directed scenarios plus random ops
// checked against a signed/unsigned integer reference model.
module tb_chunked_adder;

    logic clk = 1'b0;
    logic rst;
    logic start4, sub4, acc4;
    logic [15:0] a4, b4, sum4;
    logic busy4, done4, cout4, ovf4;
    logic start16, sub16, acc16;
    logic [15:0] a16, b16, sum16;
    logic busy16, done16, cout16, ovf16;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [15:0] msum;

    always #5 clk = ~clk;

    chunked_adder u4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .acc(acc4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4),
        .cout(cout4), .ovf(ovf4)
    );

    chunked_adder #(.WIDTH(16), .CHUNK(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .acc(acc16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .sum(sum16),
        .cout(cout16), .ovf(ovf16)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                  input logic s, output logic [15:0] r,
                                  output logic c, output logic o);
        int ux, uy, sx, sy, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            sr = sx - sy;
            c  = (ux >= uy);
            r  = 16'(ux - uy);
        end else begin
            sr = sx + sy;
            c  = (ux + uy) > 65535;
            r  = 16'(ux + uy);
        end
        o = (sr > 32767) || (sr < -32768);
`ifdef CHUNKED_ADDER_SAT_EN
        if (o) r = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
    endfunction

    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          input logic s, input logic ac, input string tag);
        logic [15:0] er;
        logic ec, eo;
        int n, bc;
        model(ac ? msum : x, y, s, er, ec, eo);
        msum = er;
        a4 = x; b4 = y; sub4 = s; acc4 = ac; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = 16'($urandom); b4 = 16'($urandom);
        sub4 = 1'($urandom); acc4 = 1'($urandom);
        n = 0; bc = 0;
        while (!done4 && n < 20) begin
            if (busy4) bc++;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, n, 4);
        chk({tag, "_busy"}, bc, 4);
        chk({tag, "_sum"}, {16'h0, sum4}, {16'h0, er});
        chk({tag, "_cout"}, {31'h0, cout4}, {31'h0, ec});
        chk({tag, "_ovf"}, {31'h0, ovf4}, {31'h0, eo});
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, {31'h0, done4}, 32'h0);
    endtask

    initial begin
        int dn;
        logic [15:0] got;
        rst = 1'b1;
        start4 = 0; sub4 = 0; acc4 = 0; a4 = 0; b4 = 0;
        start16 = 0; sub16 = 0; acc16 = 0; a16 = 0; b16 = 0;
        msum = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_sum", {16'h0, sum4}, 32'h0);
        chk("rst_busy", {31'h0, busy4}, 32'h0);
        chk("rst_done", {31'h0, done4}, 32'h0);
        chk("rst_cout", {31'h0, cout4}, 32'h0);
        chk("rst_ovf", {31'h0, ovf4}, 32'h0);
        chk("rst_sum16", {16'h0, sum16}, 32'h0);

        run_op(16'h1234, 16'h0000, 1'b0, 1'b0, "s1_add");
        chk("s1_abs", {16'h0, sum4}, 32'h1234);
        run_op(16'hAAAA, 16'h1234, 1'b0, 1'b1, "s4_acc1");
        chk("s4_abs1", {16'h0, sum4}, 32'h2468);
        run_op(16'h5555, 16'h1234, 1'b0, 1'b1, "s4_acc2");
        chk("s4_abs2", {16'h0, sum4}, 32'h369C);
        run_op(16'h7542, 16'h7579, 1'b0, 1'b0, "s2_ovf");
        run_op(16'h4213, 16'h1234, 1'b1, 1'b0, "s3_sub");
        chk("s3_abs", {16'h0, sum4}, 32'h2FDF);
        run_op(16'h0000, 16'h0001, 1'b1, 1'b0, "s3_borrow");
        chk("s3_abs2", {16'h0, sum4}, 32'hFFFF);
        run_op(16'h8000, 16'hFFFF, 1'b0, 1'b0, "neg_ovf");
        run_op(16'h0000, 16'h8000, 1'b1, 1'b0, "sub_min");

        for (int i = 0; i < 20; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0), "rnd");

        // start pulsed mid-RUN is ignored
        a4 = 16'h1111; b4 = 16'h2222; sub4 = 0; acc4 = 0; start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        @(posedge clk); #1 start4 = 1'b1; a4 = 16'hFFFF; b4 = 16'hFFFF;
        @(posedge clk); #1 start4 = 1'b0;
        dn = 0; got = 16'h0;
        for (int i = 0; i < 8; i++) begin
            if (done4) begin
                dn++;
                got = sum4;
            end
            @(posedge clk); #1;
        end
        chk("s5_one_done", dn, 1);
        chk("s5_sum", {16'h0, got}, 32'h3333);

        // reset in the third RUN cycle aborts the op
        a4 = 16'h0005; b4 = 16'h0006; start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("s5_rst_sum", {16'h0, sum4}, 32'h0);
        chk("s5_rst_busy", {31'h0, busy4}, 32'h0);
        chk("s5_rst_done", {31'h0, done4}, 32'h0);
        chk("s5_rst_cout", {31'h0, cout4}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (done4) dn++;
            @(posedge clk); #1;
        end
        chk("s5_no_done", dn, 0);
        msum = 16'h0;
        run_op(16'hBEEF, 16'h0042, 1'b0, 1'b1, "acc_after_rst");

        // single-chunk instance with start held through DONE
        a16 = 16'hFFFF; b16 = 16'h0001; start16 = 1'b1;
        @(posedge clk); #1;
        a16 = 16'h0002; b16 = 16'h0003;
        chk("s6_busy", {31'h0, busy16}, 32'h1);
        @(posedge clk); #1;
        chk("s6_done1", {31'h0, done16}, 32'h1);
        chk("s6_sum1", {16'h0, sum16}, 32'h0);
        chk("s6_cout1", {31'h0, cout16}, 32'h1);
        chk("s6_ovf1", {31'h0, ovf16}, 32'h0);
        @(posedge clk); #1;
        start16 = 1'b0;
        chk("s6_gap_done", {31'h0, done16}, 32'h0);
        chk("s6_gap_busy", {31'h0, busy16}, 32'h1);
        @(posedge clk); #1;
        chk("s6_done2", {31'h0, done16}, 32'h1);
        chk("s6_sum2", {16'h0, sum16}, 32'h5);
        chk("s6_cout2", {31'h0, cout16}, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
